// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The sign signal exists only when BIN2BCD_SIGNED_EN is defined.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) ();
    logic                  start;
    logic [WIDTH-1:0]      in_bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_SIGNED_EN
    logic                  sign;
`endif

`ifdef BIN2BCD_SIGNED_EN
    modport master (output start, output in_bin, input busy, input done, input bcd, input sign);
    modport slave  (input start, input in_bin, output busy, output done, output bcd, output sign);
`else
    modport master (output start, output in_bin, input busy, input done, input bcd);
    modport slave  (input start, input in_bin, output busy, output done, output bcd);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude in bcd plus a sign output.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [WIDTH-1:0]   op;
    logic [WIDTH-1:0]   mag;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   bcd_q;
    logic               accept;
    logic               last_bit;
`ifdef BIN2BCD_SIGNED_EN
    logic               sign_work;
    logic               sign_q;
`endif

    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit = (state == S_CONV) && (cnt == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment before the case keeps this block a pure
    // combinational function with no inferred latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nxt = S_CONV;
            S_CONV: if (last_bit)  state_nxt = S_DONE;
            S_DONE: state_nxt = bus.start ? S_CONV : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_CONV);
        bus.done = (state == S_DONE);
    end

    // Digits >= 5 get +3 so the following left shift carries correctly into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[ACC_W-2:0], op[WIDTH-1]};
    end

`ifdef BIN2BCD_SIGNED_EN
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
    assign mag = bus.in_bin[WIDTH-1] ? (~bus.in_bin + WIDTH'(1)) : bus.in_bin;
`else
    assign mag = bus.in_bin;
`endif

    // NOTE: the working registers and the result are all reset, so an aborted
    // conversion leaves nothing stale behind and bcd reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            op        <= '0;
            cnt       <= '0;
            bcd_q     <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_work <= 1'b0;
            sign_q    <= 1'b0;
`endif
        end else if (accept) begin
            acc       <= '0;
            op        <= mag;
            cnt       <= CNT_W'(WIDTH);
`ifdef BIN2BCD_SIGNED_EN
            sign_work <= bus.in_bin[WIDTH-1];
`endif
        end else if (state == S_CONV) begin
            acc <= acc_shift;
            op  <= op << 1;
            cnt <= cnt - CNT_W'(1);
            if (last_bit) begin
                bcd_q  <= acc_shift;
`ifdef BIN2BCD_SIGNED_EN
                sign_q <= sign_work;
`endif
            end
        end
    end

    assign bus.bcd  = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
    assign bus.sign = sign_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 16-bit instance for the main scenarios and
// an 8-bit instance for a back-to-back sweep. Inputs are driven and outputs sampled on negedge.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus16 ();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) bus8  ();

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));

    // Raise start for one cycle, then count edges after the accepting edge until done.
    // lat == 16 means done is high 17 cycles after the edge on which start was raised.
    task automatic conv16(input logic [15:0] v, output int lat);
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.in_bin = v;
        @(negedge clk);
        bus16.start = 1'b0;
        lat = 0;
        while (bus16.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus16.start = 1'b0; bus16.in_bin = '0;
        bus8.start  = 1'b0; bus8.in_bin  = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus16.busy); end
        checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus16.done); end
        checks++; if (bus16.bcd !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000", bus16.bcd); end
        checks++; if (bus8.bcd !== 12'h0) begin errors++; $display("FAIL reset_bcd8: got %h expected 000", bus8.bcd); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] vin [3];
        logic [19:0] vexp [3];
        int lat;
        vin[0] = 16'd0;     vexp[0] = 20'h00000;
`ifdef BIN2BCD_SIGNED_EN
        vin[1] = 16'd65535; vexp[1] = 20'h00001;
`else
        vin[1] = 16'd65535; vexp[1] = 20'h65535;
`endif
        vin[2] = 16'd9999;  vexp[2] = 20'h09999;
        for (int i = 0; i < 3; i++) begin
            conv16(vin[i], lat);
            checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected 16", i, lat); end
            checks++; if (bus16.bcd !== vexp[i]) begin errors++; $display("FAIL basic_bcd[%0d]: got %h expected %h", i, bus16.bcd, vexp[i]); end
            @(negedge clk);
            checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, bus16.done); end
            checks++; if (bus16.bcd !== vexp[i]) begin errors++; $display("FAIL basic_hold[%0d]: got %h expected %h", i, bus16.bcd, vexp[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        int ndone = 0;
        int busy_low = 0;
        logic [19:0] got = '0;
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.in_bin = 16'd1234;
        @(negedge clk);
        bus16.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                bus16.start  = 1'b1;
                bus16.in_bin = 16'd5678;
            end else if (c == 6) begin
                bus16.start = 1'b0;
            end
            @(negedge clk);
            if (bus16.done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    lat = c;
                    got = bus16.bcd;
                end
            end else if (ndone == 0 && bus16.busy !== 1'b1) begin
                busy_low++;
            end
        end
        checks++; if (lat != 16) begin errors++; $display("FAIL ignore_latency: got %0d expected 16", lat); end
        checks++; if (got !== 20'h01234) begin errors++; $display("FAIL ignore_bcd: got %h expected 01234", got); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL ignore_busy: got %0d low cycles expected 0", busy_low); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int lat;
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.in_bin = 16'd4321;
        @(negedge clk);
        bus16.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus16.bcd !== 20'h01234) begin errors++; $display("FAIL abort_hold_prev: got %h expected 01234", bus16.bcd); end
        checks++; if (bus16.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", bus16.busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus16.busy); end
        checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus16.done); end
        checks++; if (bus16.bcd !== 20'h0) begin errors++; $display("FAIL abort_bcd: got %h expected 00000", bus16.bcd); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus16.done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        checks++; if (bus16.bcd !== 20'h0) begin errors++; $display("FAIL abort_bcd_after: got %h expected 00000", bus16.bcd); end
        conv16(16'd42, lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 16", lat); end
        checks++; if (bus16.bcd !== 20'h00042) begin errors++; $display("FAIL abort_restart_bcd: got %h expected 00042", bus16.bcd); end
    endtask

`ifdef BIN2BCD_SIGNED_EN
    task automatic test_signed();
        logic [15:0] vin [3];
        logic [19:0] vexp [3];
        logic        sexp [3];
        int lat;
        vin[0] = 16'h8000; vexp[0] = 20'h32768; sexp[0] = 1'b1;
        vin[1] = 16'hFFFF; vexp[1] = 20'h00001; sexp[1] = 1'b1;
        vin[2] = 16'h7FFF; vexp[2] = 20'h32767; sexp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            conv16(vin[i], lat);
            checks++; if (lat != 16) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 16", i, lat); end
            checks++; if (bus16.bcd !== vexp[i]) begin errors++; $display("FAIL signed_bcd[%0d]: got %h expected %h", i, bus16.bcd, vexp[i]); end
            checks++; if (bus16.sign !== sexp[i]) begin errors++; $display("FAIL signed_sign[%0d]: got %b expected %b", i, bus16.sign, sexp[i]); end
        end
    endtask
`endif

    // Start held high across the whole sweep; a new operand is presented right after each done.
    task automatic test_back_to_back();
        int lat;
        int mag;
        logic [11:0] exp_bcd;
        @(negedge clk);
        bus8.start  = 1'b1;
        bus8.in_bin = 8'd0;
        for (int v = 0; v < 256; v++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (bus8.done !== 1'b1 && lat < 30);
            mag = v;
`ifdef BIN2BCD_SIGNED_EN
            if (v >= 128) mag = 256 - v;
`endif
            exp_bcd = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
            checks++; if (lat != 9) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 9", v, lat); end
            checks++; if (bus8.bcd !== exp_bcd) begin errors++; $display("FAIL b2b_bcd[%0d]: got %h expected %h", v, bus8.bcd, exp_bcd); end
            bus8.in_bin = 8'(v + 1);
        end
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", bus8.busy, bus8.done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
`ifdef BIN2BCD_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
